// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver, the RX buffer and the register
// block.
//   UART_PAYLOAD_BITS  : default character width
//   UART_RX_FIFO_DEPTH : default RX buffer depth
//   uart_rx_entry_t    : one buffered character, {BREAK flag, data}
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_PAYLOAD_BITS  = 8;
   localparam int UART_RX_FIFO_DEPTH = 8;

   typedef struct packed {
      logic                         brk;
      logic [UART_PAYLOAD_BITS-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// DEPTH x WIDTH flop array with one synchronous write port and one
// asynchronous read port. Contents are not reset; the owning FIFO masks any
// read of an unwritten location.
// Ports:
//   clk    : system clock
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module uart_fifo_ram #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 9
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];

   // Storage write; deliberately no reset on the array.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Captures single-cycle character
// pulses (data + BREAK) into a DEPTH-entry FIFO and presents the oldest entry
// on a show-ahead valid/ready port. The receiver cannot be stalled, so a write
// into a full FIFO without a coincident pop is dropped and flagged in the
// sticky overrun bit.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the character
// timeout counter driving irq_timeout; otherwise irq_timeout is tied low.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   clr                  : synchronous flush (pointers, overrun, timeout)
//   wr_valid/data/break  : received character pulse
//   rd_valid/ready       : head-entry handshake
//   rd_data/rd_break     : head entry, forced to 0 while empty
//   count/full/empty     : fill status
//   overrun, ovr_clr     : sticky drop flag and its clear
//   irq_level            : count >= THRESH
//   irq_timeout          : data waiting and idle for TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH          = UART_RX_FIFO_DEPTH,
   parameter int WIDTH          = UART_PAYLOAD_BITS,
   parameter int THRESH         = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clr,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_break,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_break,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overrun,
   input  logic                     ovr_clr,
   output logic                     irq_level,
   output logic                     irq_timeout
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam int          EW      = WIDTH + 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Elaboration-time parameter legality checks.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
   end
   if ((THRESH < 1) || (THRESH > DEPTH)) begin : g_bad_thresh
      $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("uart_rx_fifo: TIMEOUT_CYCLES must be >= 1");
   end

   // Extra MSB on each pointer makes full (MSBs differ) distinct from empty.
   logic [AW:0]     wr_ptr_r;
   logic [AW:0]     rd_ptr_r;
   logic            overrun_r;
   logic [CW-1:0]   count_s;
   logic            empty_s;
   logic            full_s;
   logic            pop_s;
   logic            push_s;
   logic            drop_s;
   logic [EW-1:0]   head_s;

   assign count_s = wr_ptr_r - rd_ptr_r;
   assign empty_s = (count_s == {CW{1'b0}});
   assign full_s  = (count_s == CW'(DEPTH));

   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign pop_s  = !empty_s && rd_ready;
   assign push_s = wr_valid && (!full_s || pop_s);
   assign drop_s = wr_valid && full_s && !pop_s;

   uart_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk   (clk),
      .we    (push_s && !clr),
      .waddr (wr_ptr_r[AW-1:0]),
      .wdata ({wr_break, wr_data}),
      .raddr (rd_ptr_r[AW-1:0]),
      .rdata (head_s)
   );

   // Pointer advance; clr overrides any coincident push or pop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else if (clr) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Sticky overrun; a drop in the same cycle wins over ovr_clr.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun_r <= 1'b0;
      end else if (clr) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (ovr_clr) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   // Head entry is masked to zero while empty so stale storage never leaks.
   always_comb begin
      rd_data  = {WIDTH{1'b0}};
      rd_break = 1'b0;
      if (!empty_s) begin
         rd_data  = head_s[WIDTH-1:0];
         rd_break = head_s[WIDTH];
      end else begin
         rd_data  = {WIDTH{1'b0}};
         rd_break = 1'b0;
      end
   end

   assign rd_valid  = !empty_s;
   assign count     = count_s;
   assign full      = full_s;
   assign empty     = empty_s;
   assign overrun   = overrun_r;
   assign irq_level = (count_s >= CW'(THRESH));

`ifdef UART_RX_FIFO_TIMEOUT_EN
   localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] idle_r;

   // Idle counter: restarts on any activity or while empty, saturates at T_MAX.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idle_r <= {TW{1'b0}};
      end else if (clr || push_s || pop_s || empty_s) begin
         idle_r <= {TW{1'b0}};
      end else if (idle_r != T_MAX) begin
         idle_r <= idle_r + TW'(1);
      end else begin
         idle_r <= idle_r;
      end
   end

   assign irq_timeout = (idle_r == T_MAX) && !empty_s;
`else
   assign irq_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer placed directly downstream of the UART receiver.
- Captures each single-cycle received-character pulse (data plus BREAK flag) into a DEPTH-entry FIFO.
- Presents the oldest entry to the bus-facing register block on a valid/ready read port.
- The receiver has no backpressure, so the FIFO reports overflow through a sticky overrun flag.
- Provides fill level and a threshold interrupt level.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- WIDTH, 8, payload bits per entry; matches the receiver's PAYLOAD_BITS.
- THRESH, 4, irq_level asserts when count >= THRESH; range 1..DEPTH.
- TIMEOUT_CYCLES, 4096, idle cycles before a character timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush.
- wr_valid  in  1  one-cycle pulse: character received (from uart_rx_valid).
- wr_data  in  WIDTH  received character.
- wr_break  in  1  character was a BREAK.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  WIDTH  head entry data.
- rd_break  out  1  head entry BREAK flag.
- count  out  $clog2(DEPTH)+1  entries held.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overrun  out  1  sticky: a character was dropped.
- ovr_clr  in  1  clears overrun.
- irq_level  out  1  count >= THRESH.
- irq_timeout  out  1  character timeout (optional feature).

Behaviour:
- Reset (resetn low, asynchronous):
  - read and write pointers, count, overrun and timeout state go to 0.
  - empty=1; full=0; rd_valid=0; irq_level=0; irq_timeout=0.
  - Storage contents are don't-care; rd_data and rd_break must be 0 whenever empty.
- Storage:
  - Each entry is {break, data}, WIDTH+1 bits.
  - Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap.
  - Index wraps from DEPTH-1 to 0 naturally.
- Read port (show-ahead):
  - rd_valid = !empty.
  - rd_data and rd_break are driven combinationally from the head entry.
  - A pop occurs when rd_valid && rd_ready. rd_ready while empty has no effect.
- Write:
  - wr_valid && (!full || pop in the same cycle): entry written at the tail.
  - Write-to-rd_valid latency is 1 cycle; data is never bypassed combinationally.
- Overflow:
  - wr_valid && full && no pop: character dropped, overrun <= 1, contents unchanged.
- Simultaneous write and pop:
  - count unchanged, both pointers advance.
  - On a full FIFO the write is accepted and overrun is not set.
- overrun:
  - Set as above; cleared by ovr_clr or clr.
  - Set has priority over ovr_clr in the same cycle.
- clr:
  - Next cycle: pointers 0, count 0, overrun 0, timeout state cleared.
  - Overrides any write or pop in the same cycle; that write is discarded without setting overrun.
- count, full, empty and irq_level are registered-state derived; they change only on the clock edge after a push or pop.
- wr_data and wr_break are sampled only on wr_valid.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - An idle counter of $clog2(TIMEOUT_CYCLES+1) bits resets to 0 on any accepted write, pop, clr, or while empty; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - irq_timeout is asserted when counter == TIMEOUT_CYCLES and !empty.
  - It deasserts on the cycle after the next pop, write or clr.
- Undefined:
  - No counter is built, irq_timeout is tied 0, TIMEOUT_CYCLES is ignored.
  - Port list is unchanged.

Decomposition:
- Package uart_pkg holds:
  - typedef uart_rx_entry_t (packed struct {logic brk; logic [WIDTH-1:0] data}).
  - Default constants UART_PAYLOAD_BITS=8 and UART_RX_FIFO_DEPTH=8, shared with uart_rx and the register block.
- One sub-module, uart_fifo_ram:
  - DEPTH x (WIDTH+1) flop array, one write port and one asynchronous read port, no reset on contents.
  - Reusable by a future TX FIFO.
- Pointer, count, flag and timeout logic stays in uart_rx_fifo.

Test Plan (DEPTH=4, THRESH=2, TIMEOUT_CYCLES=16):
- Reset then idle: empty=1, rd_valid=0, count=0, rd_data=0 for 10 cycles; rd_ready=1 throughout causes no change.
- Push 0x41, 0x42, 0x43 with rd_ready=0:
  - rd_valid rises 1 cycle after the first pulse.
  - count=3; irq_level=1 after the 2nd push.
  - Pop order 0x41, 0x42, 0x43, then empty=1.
- Push 5 chars 0x10..0x14 with no pops:
  - full=1 after the 4th push.
  - 0x14 dropped, overrun=1.
  - Pops yield 0x10..0x13.
  - overrun stays 1 until ovr_clr, then 0.
- Full FIFO with wr_valid (0x55) and rd_ready in the same cycle: overrun stays 0, count stays 4, 0x55 emerges 4th.
- Push BREAK (data 0x00, break=1) then 0x7E: first pop rd_break=1, rd_data=0x00; second pop rd_break=0, rd_data=0x7E.
- clr asserted with 3 entries plus a coincident wr_valid: next cycle count=0, empty=1, overrun=0.
  - With UART_RX_FIFO_TIMEOUT_EN: push 1 char, hold rd_ready=0; irq_timeout rises 16 cycles after the push and clears the cycle after the pop.
- Assert resetn low mid-stream with 2 entries: all outputs return to reset values without a clock edge.
